// File: rtl/cycle_sequencer_if.sv
// Bus between the TB4004 core front end and the machine-cycle sequencer.
// The master drives run and the ROM nibble bus; the sequencer (slave) drives phase and strobes.
interface cycle_sequencer_if;
  logic       run;
  logic       romValid;
  logic [3:0] romData;
  logic [2:0] cycle;
  logic       sync;
  logic [3:0] opr;
  logic [3:0] opa;
  logic [3:0] operandHi;
  logic [3:0] operandLo;
  logic       secondWord;
  logic       pcInc;
  logic       instrDone;

  modport master (
    output run, romValid, romData,
    input  cycle, sync, opr, opa, operandHi, operandLo, secondWord, pcInc, instrDone
  );

  modport slave (
    input  run, romValid, romData,
    output cycle, sync, opr, opa, operandHi, operandLo, secondWord, pcInc, instrDone
  );
endinterface

// File: rtl/cycle_sequencer.sv
// Eight-phase machine-cycle controller for the TB4004: fetches OPR/OPA, sequences two-word
// instructions and issues SYNC/PC-increment/done strobes. Define CYCLE_SEQ_STALL_EN to stall M1/M2 on romValid=0.
module cycle_sequencer (
  input  logic              clk,
  input  logic              rst,
  cycle_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FIRST  = 2'd1,
    SECOND = 2'd2
  } state_e;

  localparam logic [2:0] PH_M1 = 3'd3;
  localparam logic [2:0] PH_M2 = 3'd4;
  localparam logic [2:0] PH_X3 = 3'd7;

  state_e     state_q, state_d;
  logic [2:0] cycle_q, cycle_d;
  logic [3:0] opr_q, opr_d;
  logic [3:0] opa_q, opa_d;
  logic [3:0] operand_hi_q, operand_hi_d;
  logic [3:0] operand_lo_q, operand_lo_d;
  logic       two_word_q, two_word_d;
  logic       sync_q, sync_d;
  logic       second_word_q, second_word_d;
  logic       pc_inc_q, pc_inc_d;
  logic       instr_done_q, instr_done_d;
  logic       rom_ok;
  logic       stall;

  // JCN, FIM (even OPA), JUN, JMS and ISZ carry a second ROM word.
  function automatic logic is_two_word(input logic [3:0] op_hi, input logic [3:0] op_lo);
    logic res;
    res = 1'b0;
    case (op_hi)
      4'h1, 4'h4, 4'h5, 4'h7: res = 1'b1;
      4'h2:                   res = ~op_lo[0];
      default:                res = 1'b0;
    endcase
    return res;
  endfunction

`ifdef CYCLE_SEQ_STALL_EN
  assign rom_ok = bus.romValid;
`else
  logic unused_rom_valid;
  assign unused_rom_valid = bus.romValid;
  assign rom_ok = 1'b1;
`endif

  assign stall = ((cycle_q == PH_M1) || (cycle_q == PH_M2)) && !rom_ok;

  always_comb begin
    state_d      = state_q;
    cycle_d      = cycle_q;
    opr_d        = opr_q;
    opa_d        = opa_q;
    operand_hi_d = operand_hi_q;
    operand_lo_d = operand_lo_q;
    two_word_d   = two_word_q;
    pc_inc_d     = 1'b0;
    instr_done_d = 1'b0;

    if (state_q == IDLE) begin
      cycle_d = 3'd0;
      if (bus.run) state_d = FIRST;
    end else if (!stall) begin
      cycle_d = cycle_q + 3'd1;

      if (cycle_q == PH_M1) begin
        if (state_q == SECOND) operand_hi_d = bus.romData;
        else                   opr_d        = bus.romData;
      end

      if (cycle_q == PH_M2) begin
        pc_inc_d = 1'b1;
        if (state_q == SECOND) begin
          operand_lo_d = bus.romData;
        end else begin
          opa_d      = bus.romData;
          two_word_d = is_two_word(opr_q, bus.romData);
        end
      end

      // Instruction boundary: either chain into the second word or retire and resample run.
      if (cycle_q == PH_X3) begin
        cycle_d = 3'd0;
        if ((state_q == FIRST) && two_word_q) begin
          state_d = SECOND;
        end else begin
          instr_done_d = 1'b1;
          two_word_d   = 1'b0;
          state_d      = bus.run ? FIRST : IDLE;
        end
      end
    end

    sync_d        = (cycle_d == PH_X3) && (state_d != IDLE);
    second_word_d = (state_d == SECOND);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cycle_q       <= 3'd0;
      opr_q         <= 4'd0;
      opa_q         <= 4'd0;
      operand_hi_q  <= 4'd0;
      operand_lo_q  <= 4'd0;
      two_word_q    <= 1'b0;
      sync_q        <= 1'b0;
      second_word_q <= 1'b0;
      pc_inc_q      <= 1'b0;
      instr_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      cycle_q       <= cycle_d;
      opr_q         <= opr_d;
      opa_q         <= opa_d;
      operand_hi_q  <= operand_hi_d;
      operand_lo_q  <= operand_lo_d;
      two_word_q    <= two_word_d;
      sync_q        <= sync_d;
      second_word_q <= second_word_d;
      pc_inc_q      <= pc_inc_d;
      instr_done_q  <= instr_done_d;
    end
  end

  assign bus.cycle      = cycle_q;
  assign bus.sync       = sync_q;
  assign bus.opr        = opr_q;
  assign bus.opa        = opa_q;
  assign bus.operandHi  = operand_hi_q;
  assign bus.operandLo  = operand_lo_q;
  assign bus.secondWord = second_word_q;
  assign bus.pcInc      = pc_inc_q;
  assign bus.instrDone  = instr_done_q;

endmodule

// File: tb/tb_cycle_sequencer.sv
// Directed-vector bench for cycle_sequencer: single/two-word fetch, FIM boundary,
// run drop at X1, reset in SECOND and romValid handling (stall when CYCLE_SEQ_STALL_EN).
module tb_cycle_sequencer;

  logic clk;
  logic rst;
  int   nvec;
  int   nmis;
  int   len;

  cycle_sequencer_if bus();

  cycle_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_cycle"}, {5'd0, bus.cycle}, 8'd0);
    check_val({tag, "_sync"}, {7'd0, bus.sync}, 8'd0);
    check_val({tag, "_opr"}, {4'd0, bus.opr}, 8'd0);
    check_val({tag, "_opa"}, {4'd0, bus.opa}, 8'd0);
    check_val({tag, "_ophi"}, {4'd0, bus.operandHi}, 8'd0);
    check_val({tag, "_oplo"}, {4'd0, bus.operandLo}, 8'd0);
    check_val({tag, "_second"}, {7'd0, bus.secondWord}, 8'd0);
    check_val({tag, "_pcinc"}, {7'd0, bus.pcInc}, 8'd0);
    check_val({tag, "_done"}, {7'd0, bus.instrDone}, 8'd0);
  endtask

  // One unstalled word starting at A1: feeds hi in M1, lo in M2, sets run at X1.
  task automatic do_word(input logic [3:0] hi, input logic [3:0] lo, input logic exp_second,
                         input logic exp_done_a1, input logic run_x1);
    for (int k = 0; k < 8; k++) begin
      bus.romValid = 1'b1;
      bus.romData  = (k == 3) ? hi : (k == 4) ? lo : 4'hF;
      if (k == 5) bus.run = run_x1;
      check_val("w_cycle", {5'd0, bus.cycle}, k[7:0]);
      check_val("w_second", {7'd0, bus.secondWord}, {7'd0, exp_second});
      check_val("w_sync", {7'd0, bus.sync}, {7'd0, (k == 7)});
      check_val("w_pcinc", {7'd0, bus.pcInc}, {7'd0, (k == 5)});
      check_val("w_done", {7'd0, bus.instrDone}, {7'd0, (k == 0) ? exp_done_a1 : 1'b0});
      tick();
    end
  endtask

  initial begin
    nvec = 0;
    nmis = 0;
    rst = 1'b1;
    bus.run = 1'b0;
    bus.romValid = 1'b1;
    bus.romData = 4'h0;
    tick();
    check_all_zero("rst");
    rst = 1'b0;
    tick();
    tick();
    check_val("idle_cycle", {5'd0, bus.cycle}, 8'd0);
    check_val("idle_sync", {7'd0, bus.sync}, 8'd0);

    // ADD R3: single word, done pulse lands at A1 of the next instruction.
    bus.run = 1'b1;
    tick();
    do_word(4'h8, 4'h3, 1'b0, 1'b0, 1'b1);
    check_val("add_opr", {4'd0, bus.opr}, 8'h8);
    check_val("add_opa", {4'd0, bus.opa}, 8'h3);

    // JUN 0x123: two words, opr/opa held across the second word.
    do_word(4'h4, 4'h1, 1'b0, 1'b1, 1'b1);
    do_word(4'h2, 4'h3, 1'b1, 1'b0, 1'b1);
    check_val("jun_opr", {4'd0, bus.opr}, 8'h4);
    check_val("jun_opa", {4'd0, bus.opa}, 8'h1);
    check_val("jun_ophi", {4'd0, bus.operandHi}, 8'h2);
    check_val("jun_oplo", {4'd0, bus.operandLo}, 8'h3);

    // FIM (even OPA) is two words; SRC (odd OPA) is one.
    do_word(4'h2, 4'h0, 1'b0, 1'b1, 1'b1);
    do_word(4'h5, 4'h6, 1'b1, 1'b0, 1'b1);
    check_val("fim_ophi", {4'd0, bus.operandHi}, 8'h5);
    check_val("fim_oplo", {4'd0, bus.operandLo}, 8'h6);
    do_word(4'h2, 4'h1, 1'b0, 1'b1, 1'b1);

    // Drop run at X1: the instruction completes, then the sequencer parks in IDLE.
    do_word(4'hC, 4'h0, 1'b0, 1'b1, 1'b0);
    check_val("drop_done", {7'd0, bus.instrDone}, 8'd1);
    check_val("drop_cycle", {5'd0, bus.cycle}, 8'd0);
    check_val("drop_sync", {7'd0, bus.sync}, 8'd0);
    check_val("drop_second", {7'd0, bus.secondWord}, 8'd0);
    tick();
    tick();
    check_val("parked_cycle", {5'd0, bus.cycle}, 8'd0);
    check_val("parked_done", {7'd0, bus.instrDone}, 8'd0);
    check_val("parked_sync", {7'd0, bus.sync}, 8'd0);

    // Reset at phase 5 of a second word clears everything on the next cycle.
    bus.run = 1'b1;
    tick();
    do_word(4'h5, 4'h1, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      bus.romData = (k == 3) ? 4'h7 : (k == 4) ? 4'h9 : 4'hF;
      tick();
    end
    check_val("pre_rst_cycle", {5'd0, bus.cycle}, 8'd5);
    check_val("pre_rst_second", {7'd0, bus.secondWord}, 8'd1);
    check_val("pre_rst_ophi", {4'd0, bus.operandHi}, 8'h7);
    check_val("pre_rst_pcinc", {7'd0, bus.pcInc}, 8'd1);
    rst = 1'b1;
    bus.run = 1'b0;
    tick();
    rst = 1'b0;
    check_all_zero("mid_rst");

    // M1 with romValid low: stalls three cycles when enabled, otherwise ignored.
    bus.run = 1'b1;
    bus.romValid = 1'b1;
    tick();
    len = 1;
    for (int k = 0; k < 3; k++) begin
      check_val("st_cycle", {5'd0, bus.cycle}, k[7:0]);
      tick();
      len++;
    end
`ifdef CYCLE_SEQ_STALL_EN
    for (int s = 0; s < 3; s++) begin
      bus.romValid = 1'b0;
      bus.romData  = 4'h4;
      check_val("stall_cycle", {5'd0, bus.cycle}, 8'd3);
      check_val("stall_sync", {7'd0, bus.sync}, 8'd0);
      check_val("stall_pcinc", {7'd0, bus.pcInc}, 8'd0);
      tick();
      len++;
    end
    bus.romValid = 1'b1;
`else
    bus.romValid = 1'b0;
`endif
    bus.romData = 4'hA;
    check_val("st_m1_cycle", {5'd0, bus.cycle}, 8'd3);
    tick();
    len++;
    bus.romValid = 1'b1;
    bus.romData  = 4'h5;
    bus.run      = 1'b0;
    tick();
    len++;
    while (!bus.instrDone && len < 30) begin
      check_val("st_second", {7'd0, bus.secondWord}, 8'd0);
      tick();
      len++;
    end
`ifdef CYCLE_SEQ_STALL_EN
    check_val("st_len", len[7:0], 8'd12);
`else
    check_val("st_len", len[7:0], 8'd9);
`endif
    check_val("st_opr", {4'd0, bus.opr}, 8'hA);
    check_val("st_opa", {4'd0, bus.opa}, 8'h5);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/cycle_sequencer.md
# cycle_sequencer

Machine-cycle controller for the TB4004 core. Generates the eight-phase instruction cycle (A1, A2, A3, M1, M2, X1, X2, X3 encoded 0 to 7) that drives the instruction decoder and ALU. Fetches the OPR/OPA nibbles from ROM, detects two-word instructions, and sequences the second word. Issues PC-increment, SYNC and instruction-done strobes, and optionally stalls on a slow ROM.

## Interface
Parameters:
- none

Ports:
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  synchronous reset, active-high
- run  in  1  permit to start or continue instructions; sampled only at instruction boundaries
- romValid  in  1  ROM nibble on romData valid this cycle; used in M1/M2 only
- romData  in  4  ROM nibble bus
- cycle  out  3  current phase: 0=A1 … 3=M1, 4=M2 … 7=X3
- sync  out  1  high during X3 of every active word
- opr  out  4  first-word upper nibble, latched at end of first-word M1
- opa  out  4  first-word lower nibble, latched at end of first-word M2
- operandHi  out  4  second-word upper nibble, latched at end of second-word M1
- operandLo  out  4  second-word lower nibble, latched at end of second-word M2
- secondWord  out  1  high for all eight phases of a second-word fetch
- pcInc  out  1  one-cycle pulse during X1 of every word
- instrDone  out  1  one-cycle pulse in the cycle after the final X3 of an instruction

## Operation
- States:
  - IDLE: cycle held at 0, sync=0.
  - FIRST: fetching and executing the first word.
  - SECOND: fetching the second word.
- IDLE→FIRST: on an edge with run=1. Otherwise stay in IDLE.
- In FIRST or SECOND, cycle increments by 1 per edge, wrapping 7→0, except during stalls.
- Edge leaving M1 (cycle=3, romValid=1):
  - FIRST: opr←romData.
  - SECOND: operandHi←romData.
- Edge leaving M2 (cycle=4, romValid=1):
  - FIRST: opa←romData.
  - SECOND: operandLo←romData.
  - pcInc=1 for the following cycle in both cases.
- Two-word flag: registered at the edge leaving first-word M2. It is true when any of the following holds:
  - opr=0x1 (JCN)
  - opr=0x2 and romData[0]=0 (FIM)
  - opr=0x4 (JUN)
  - opr=0x5 (JMS)
  - opr=0x7 (ISZ)
- Edge leaving X3:
  - FIRST with two-word flag set: go to SECOND, cycle=0. No instrDone.
  - Otherwise: instrDone=1 for the next cycle. Go to FIRST if run=1, else IDLE. cycle=0. Clear two-word flag.
- opr and opa hold through SECOND and until the next first-word M1/M2 latch. operandHi and operandLo hold until the next second-word latch.
- secondWord = (state==SECOND). sync = (cycle==7 and state≠IDLE). Both are driven from registers with no combinational path from inputs.
- run falling mid-instruction has no effect until the boundary.
- Reset: every output goes to 0 and state goes to IDLE on the edge where rst=1, regardless of phase or pending stall. rst has priority over all other inputs.

## Timing
- Reset values: cycle=0, sync=0, opr=0, opa=0, operandHi=0, operandLo=0, secondWord=0, pcInc=0, instrDone=0.
- Start latency: one cycle in IDLE. A1 of the first instruction begins in the cycle after the first edge with run=1.
- Unstalled single-word instruction: 8 cycles. Two-word instruction: 16 cycles.
- Back-to-back instructions with run=1: no bubble. X3 is followed directly by A1.
- instrDone and the next A1 occur in the same cycle.
- pcInc is asserted exactly once per word and never during a stall.

## Configuration
- CYCLE_SEQ_STALL_EN defined:
  - romValid=0 in M1 or M2 holds cycle and suppresses the nibble latch.
  - Stall length is unbounded.
  - sync, pcInc and instrDone stay 0 while stalled.
- Undefined: romValid is ignored and treated as 1. Every instruction takes exactly 8 or 16 cycles.

## Test plan
- Reset, then run=1 with ROM nibbles 0x8,0x3 (ADD R3):
  - opr=8, opa=3, secondWord never 1.
  - pcInc pulses once in X1.
  - instrDone pulses 9 cycles after the first run=1 edge.
- ROM 0x4,0x1,0x2,0x3 (JUN 0x123):
  - secondWord high for cycles 9–16.
  - operandHi=2, operandLo=3, opr=4, opa=1 held.
  - pcInc pulses twice; a single instrDone after cycle 16.
- FIM boundary:
  - 0x2,0x0 takes 16 cycles.
  - 0x2,0x1 (SRC) takes 8 cycles.
- With CYCLE_SEQ_STALL_EN, romValid=0 for 3 cycles in M1:
  - cycle holds at 3 for 3 extra cycles.
  - opr latches only on the valid cycle.
  - Total instruction length is 11 cycles.
- Mid-operation control:
  - Drop run during X1: the current instruction completes, then IDLE with cycle=0 and sync=0.
  - Assert rst at cycle=5 of SECOND: all outputs read 0 on the next cycle.
